// File: rtl/sdram_cmd_scheduler.sv
// Arbitrates the shared SDRAM command sequencer between Zorro II accesses and auto-refresh,
// after running the power-up init sequence.
//  state          | meaning
//  S_INIT_WAIT    | NOP hold-off after reset
//  S_INIT_PALL    | init precharge-all in flight
//  S_INIT_REF1/2  | init auto-refreshes in flight
//  S_INIT_LMR     | init load-mode in flight
//  S_IDLE         | deciding next op
//  S_RUN_ACCESS   | bus access op in flight
//  S_RUN_REFRESH  | refresh op in flight
//  S_ACK_HOLD     | access done, waiting for bus_req to drop
module sdram_cmd_scheduler #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_PENDING      = 4,
  parameter int INIT_WAIT        = 20000
) (
  input  logic       MEMCLK,
  input  logic       RESET_n,
  input  logic       bus_req,
  output logic       bus_ack,
  output logic       op_start,
  output logic [2:0] op_code,
  input  logic       op_done,
  output logic       init_done,
  output logic [2:0] refresh_pending,
  output logic       refresh_overrun
);

  localparam int WAIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam int REF_W  = $clog2(REFRESH_INTERVAL);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(INIT_WAIT - 1);
  localparam logic [REF_W-1:0]  REF_LOAD  = REF_W'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]        PEND_MAX  = 3'(MAX_PENDING);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_PALL   = 3'b001;
  localparam logic [2:0] OP_REF    = 3'b010;
  localparam logic [2:0] OP_LMR    = 3'b011;
  localparam logic [2:0] OP_ACCESS = 3'b100;

  typedef enum logic [3:0] {
    S_INIT_WAIT,
    S_INIT_PALL,
    S_INIT_REF1,
    S_INIT_REF2,
    S_INIT_LMR,
    S_IDLE,
    S_RUN_ACCESS,
    S_RUN_REFRESH,
    S_ACK_HOLD
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [REF_W-1:0]  ref_cnt;
  logic              refresh_tick;
  logic              refresh_dec;

  assign refresh_tick = init_done && (ref_cnt == '0);
  assign refresh_dec  = (state == S_RUN_REFRESH) && op_done;

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= S_INIT_WAIT;
      wait_cnt  <= WAIT_LOAD;
      op_start  <= 1'b0;
      op_code   <= OP_NOP;
      bus_ack   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      op_start <= 1'b0;
      bus_ack  <= 1'b0;
      case (state)
        S_INIT_WAIT: begin
          if (wait_cnt == '0) begin
            state    <= S_INIT_PALL;
            op_start <= 1'b1;
            op_code  <= OP_PALL;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        S_INIT_PALL: begin
          if (op_done) begin
            state    <= S_INIT_REF1;
            op_start <= 1'b1;
            op_code  <= OP_REF;
          end
        end
        S_INIT_REF1: begin
          if (op_done) begin
            state    <= S_INIT_REF2;
            op_start <= 1'b1;
            op_code  <= OP_REF;
          end
        end
        S_INIT_REF2: begin
          if (op_done) begin
            state    <= S_INIT_LMR;
            op_start <= 1'b1;
            op_code  <= OP_LMR;
          end
        end
        S_INIT_LMR: begin
          if (op_done) begin
            state     <= S_IDLE;
            op_code   <= OP_NOP;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          // A full backlog beats a waiting access so refresh can never be starved.
          if (refresh_pending == PEND_MAX) begin
            state    <= S_RUN_REFRESH;
            op_start <= 1'b1;
            op_code  <= OP_REF;
          end else if (bus_req) begin
            state    <= S_RUN_ACCESS;
            op_start <= 1'b1;
            op_code  <= OP_ACCESS;
          end else if (refresh_pending != 3'd0) begin
            state    <= S_RUN_REFRESH;
            op_start <= 1'b1;
            op_code  <= OP_REF;
          end else begin
            op_code <= OP_NOP;
          end
        end
        S_RUN_ACCESS: begin
          if (op_done) begin
            state   <= S_ACK_HOLD;
            bus_ack <= 1'b1;
            op_code <= OP_NOP;
          end
        end
        S_RUN_REFRESH: begin
          if (op_done) begin
            state   <= S_IDLE;
            op_code <= OP_NOP;
          end
        end
        S_ACK_HOLD: begin
          if (!bus_req) state <= S_IDLE;
        end
        default: begin
          state   <= S_INIT_WAIT;
          op_code <= OP_NOP;
        end
      endcase
    end
  end

  // A tick and a completed refresh in the same cycle cancel out.
  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ref_cnt         <= REF_LOAD;
      refresh_pending <= 3'd0;
      refresh_overrun <= 1'b0;
    end else begin
      if (init_done) begin
        if (ref_cnt == '0) ref_cnt <= REF_LOAD;
        else               ref_cnt <= ref_cnt - 1'b1;
      end
      if (refresh_tick && !refresh_dec) begin
        if (refresh_pending == PEND_MAX) refresh_overrun <= 1'b1;
        else                             refresh_pending <= refresh_pending + 3'd1;
      end else if (refresh_dec && !refresh_tick) begin
        refresh_pending <= refresh_pending - 3'd1;
      end
    end
  end

endmodule
